// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Stall masks are contiguous from bit 0 so a held stage always holds every earlier stage.
package pipeline_ctrl_pkg;

    localparam int          CNT_W_DEF      = 6;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
    localparam logic [31:0] EXCP_ERET      = 32'h0000_000e;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

    localparam logic [5:0]  STALL_NONE     = 6'b000000;
    localparam logic [5:0]  STALL_ID       = 6'b000111;
    localparam logic [5:0]  STALL_EX       = 6'b001111;

    typedef enum logic {
        PC_RUN    = 1'b0,
        PC_EXBUSY = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall/flush scheduler.
interface pipeline_ctrl_if #(parameter int CNT_W = 6);
    logic             stallreq_id;
    logic             ex_mc_req;
    logic [CNT_W-1:0] ex_mc_len;
    logic             excp_valid;
    logic [31:0]      excp_type;
    logic [31:0]      cp0_epc;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             ex_mc_done;
    logic             ex_mc_abort;

    modport master (
        output stallreq_id, ex_mc_req, ex_mc_len, excp_valid, excp_type, cp0_epc,
        input  stall, flush, new_pc, ex_mc_done, ex_mc_abort
    );

    modport slave (
        input  stallreq_id, ex_mc_req, ex_mc_len, excp_valid, excp_type, cp0_epc,
        output stall, flush, new_pc, ex_mc_done, ex_mc_abort
    );
endinterface

// File: rtl/pipe_mc_timer.sv
// EX multi-cycle busy counter: clear beats load beats decrement; never decrements past zero.
module pipe_mc_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign cnt  = cnt_reg;
    assign zero = (cnt_reg == '0);
endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler: merges ID hazards, EX multi-cycle ops and exceptions/eret
// into one stall vector and flush strobe for all pipeline registers.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int          CNT_W      = CNT_W_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    pc_state_t        state_reg, state_next;
    logic             tmr_clr, tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_cnt;
    logic [5:0]       stall_next;
    logic             flush_next, done_next, abort_next;
    logic [31:0]      new_pc_next, excp_target;

    pipe_mc_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (bus.ex_mc_len - CNT_W'(2)),
        .dec      (tmr_dec),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    assign excp_target = (bus.excp_type == EXCP_ERET) ? bus.cp0_epc : EXC_VECTOR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= PC_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        stall_next  = STALL_NONE;
        flush_next  = 1'b0;
        new_pc_next = ZERO_WORD;
        done_next   = 1'b0;
        abort_next  = 1'b0;
        tmr_clr     = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        if (rst) begin
            state_next = PC_RUN;
        end else begin
            unique case (state_reg)
                PC_RUN: begin
                    if (bus.excp_valid) begin
                        flush_next  = 1'b1;
                        new_pc_next = excp_target;
                    end else if (bus.ex_mc_req) begin
                        // Ops of length 0/1 finish in the request cycle and need no hold.
                        if (bus.ex_mc_len >= CNT_W'(2)) begin
                            stall_next = STALL_EX;
                            tmr_load   = 1'b1;
                            state_next = PC_EXBUSY;
                        end else begin
                            done_next  = 1'b1;
                        end
                    end else if (bus.stallreq_id) begin
                        stall_next = STALL_ID;
                    end
                end
                PC_EXBUSY: begin
                    if (bus.excp_valid) begin
                        flush_next  = 1'b1;
                        new_pc_next = excp_target;
                        abort_next  = 1'b1;
                        tmr_clr     = 1'b1;
                        state_next  = PC_RUN;
                    end else if (!tmr_zero) begin
                        stall_next = STALL_EX;
                        tmr_dec    = 1'b1;
                    end else begin
                        done_next  = 1'b1;
                        stall_next = bus.stallreq_id ? STALL_ID : STALL_NONE;
                        state_next = PC_RUN;
                    end
                end
                default: state_next = PC_RUN;
            endcase
        end
    end

    assign bus.stall       = stall_next;
    assign bus.flush       = flush_next;
    assign bus.new_pc      = new_pc_next;
    assign bus.ex_mc_done  = done_next;
    assign bus.ex_mc_abort = abort_next;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scenarios plus random traffic, checked cycle by cycle against a busy-cycles-left model.
module tb_pipeline_ctrl;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   busy_left  = 0;   // cycles until the in-flight op's done cycle; 0 = idle

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W), .EXC_VECTOR(32'h0000_0020)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs mid-cycle, advance model.
    task automatic cyc(input logic r, input logic sid, input logic req, input int len,
                       input logic ev, input logic [31:0] et, input logic [31:0] epc);
        logic [5:0]  e_stall;
        logic        e_flush, e_done, e_abort;
        logic [31:0] e_pc;
        int          nxt;
        rst = r;
        bus.stallreq_id = sid;
        bus.ex_mc_req   = req;
        bus.ex_mc_len   = CNT_W'(len);
        bus.excp_valid  = ev;
        bus.excp_type   = et;
        bus.cp0_epc     = epc;
        e_stall = 6'b0; e_flush = 0; e_done = 0; e_abort = 0; e_pc = 32'h0;
        nxt = busy_left;
        if (r) begin
            nxt = 0;
        end else if (ev) begin
            e_flush = 1;
            e_pc    = (et == 32'he) ? epc : 32'h20;
            e_abort = (busy_left != 0);
            nxt     = 0;
        end else if (busy_left > 1) begin
            e_stall = 6'b001111;
            nxt     = busy_left - 1;
        end else if (busy_left == 1) begin
            e_done  = 1;
            e_stall = sid ? 6'b000111 : 6'b0;
            nxt     = 0;
        end else if (req) begin
            if (len >= 2) begin
                e_stall = 6'b001111;
                nxt     = len - 1;
            end else begin
                e_done  = 1;
            end
        end else if (sid) begin
            e_stall = 6'b000111;
        end
        #2;
        $display("cyc t=%0t rst=%0b sid=%0b req=%0b len=%0d ev=%0b type=%h | stall=%b flush=%0b pc=%h done=%0b abort=%0b",
                 $time, r, sid, req, len, ev, et, bus.stall, bus.flush, bus.new_pc,
                 bus.ex_mc_done, bus.ex_mc_abort);
        chk("stall", 32'(bus.stall), 32'(e_stall));
        chk("flush", 32'(bus.flush), 32'(e_flush));
        chk("done",  32'(bus.ex_mc_done), 32'(e_done));
        chk("abort", 32'(bus.ex_mc_abort), 32'(e_abort));
        if (e_flush || r) chk("new_pc", bus.new_pc, e_pc);
        @(posedge clk);
        busy_left = nxt;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        bus.stallreq_id = 0; bus.ex_mc_req = 0; bus.ex_mc_len = '0;
        bus.excp_valid = 0; bus.excp_type = '0; bus.cp0_epc = '0;
        @(posedge clk); #1;
        // Reset held two cycles while an op is requested
        cyc(1, 0, 1, 5, 0, 32'h0, 32'h0);
        cyc(1, 1, 1, 5, 1, 32'he, 32'h1234);
        idle(2);
        // ID stall for 3 cycles
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 32'h0, 32'h0);
        idle(1);
        // Div of length 34, with ID stall and new requests ignored while busy
        cyc(0, 0, 1, 34, 0, 32'h0, 32'h0);
        for (int i = 0; i < 33; i++) cyc(0, (i % 3) == 0, (i % 7) == 0, 9, 0, 32'h0, 32'h0);
        idle(1);
        // Short ops
        cyc(0, 0, 1, 1, 0, 32'h0, 32'h0);
        cyc(0, 0, 1, 0, 0, 32'h0, 32'h0);
        cyc(0, 0, 1, 2, 0, 32'h0, 32'h0);
        cyc(0, 1, 0, 0, 0, 32'h0, 32'h0);
        idle(1);
        // Abort: len 10, exception on 4th busy cycle
        cyc(0, 0, 1, 10, 0, 32'h0, 32'h0);
        idle(3);
        cyc(0, 0, 0, 0, 1, 32'h8, 32'hdead_beef);
        idle(10);
        // Eret beats ID stall; back-to-back exceptions
        cyc(0, 1, 0, 0, 1, 32'he, 32'hbfc0_0100);
        cyc(0, 1, 1, 5, 1, 32'h4, 32'h0);
        idle(1);
        // Reset in the middle of a busy op
        cyc(0, 0, 1, 20, 0, 32'h0, 32'h0);
        idle(4);
        cyc(1, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(3);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] et;
            et = ($urandom_range(0, 1) == 0) ? 32'he : 32'($urandom_range(0, 31));
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 5) == 0, int'($urandom_range(0, 12)),
                $urandom_range(0, 19) == 0, et, $urandom);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
